// File: rtl/sp_pp_gen_if.sv
// sp_pp_gen_if
//   Bundles the streams and memory ports of the SpGEMM partial-product
//   generator so one port carries everything besides clock and reset.
//   A stream  : a_valid/a_ready/a_val/a_row/a_col/a_last (into the block)
//   rowptr rd : ptr_rd_en/ptr_addr out, ptr_rdata back one cycle later
//   B elem rd : elem_rd_en/elem_addr out, elem_val/elem_col back one cycle later
//   product   : out_valid/out_ready/out_val/out_row/out_col/out_last
//   done      : one-cycle pulse when the final A nonzero is fully processed
//   modport master = the generator, modport slave = its environment.
interface sp_pp_gen_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int PTR_W  = 16
);
  logic              a_valid, a_ready, a_last;
  logic [DATA_W-1:0] a_val;
  logic [IDX_W-1:0]  a_row, a_col;

  logic              ptr_rd_en;
  logic [IDX_W-1:0]  ptr_addr;
  logic [PTR_W-1:0]  ptr_rdata;

  logic              elem_rd_en;
  logic [PTR_W-1:0]  elem_addr;
  logic [DATA_W-1:0] elem_val;
  logic [IDX_W-1:0]  elem_col;

  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_val;
  logic [IDX_W-1:0]  out_row, out_col;
  logic              done;

  modport master (
    input  a_valid, a_val, a_row, a_col, a_last,
    output a_ready,
    output ptr_rd_en, ptr_addr,
    input  ptr_rdata,
    output elem_rd_en, elem_addr,
    input  elem_val, elem_col,
    output out_valid, out_val, out_row, out_col, out_last,
    input  out_ready,
    output done
  );

  modport slave (
    output a_valid, a_val, a_row, a_col, a_last,
    input  a_ready,
    input  ptr_rd_en, ptr_addr,
    output ptr_rdata,
    input  elem_rd_en, elem_addr,
    output elem_val, elem_col,
    input  out_valid, out_val, out_row, out_col, out_last,
    output out_ready,
    input  done
  );
endinterface

// File: rtl/sp_pp_gen.sv
// sp_pp_gen
//   Row-wise (Gustavson) SpGEMM partial-product generator. For each A
//   nonzero (i,k,a) it reads rowptr[k] and rowptr[k+1], then walks row k of
//   B and emits (i, j, a*b) per B nonzero on a registered valid/ready stream.
//   Ports: clk, rst_n (async, active low), bus (sp_pp_gen_if.master).
module sp_pp_gen #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int PTR_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  sp_pp_gen_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_PTR_LO, S_PTR_HI, S_LOAD, S_EMIT} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
  } beat_t;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_val_q, a_val_d;
  logic [IDX_W-1:0]  a_row_q, a_row_d, a_col_q, a_col_d;
  logic              a_last_q, a_last_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, end_q, end_d;
  beat_t             out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;

  logic [PTR_W-1:0]  ptr_inc;
  logic              more;
  logic [DATA_W-1:0] prod;

  assign ptr_inc = ptr_q + PTR_W'(1);
  // Extra bit so ptr_q at the top of the address space never wraps into "more".
  assign more    = ({1'b0, ptr_q} + (PTR_W+1)'(1)) < {1'b0, end_q};
  // Low DATA_W bits of the unsigned product.
  assign prod    = a_val_q * bus.elem_val;

  assign bus.out_valid = out_valid_q;
  assign bus.out_val   = out_q.val;
  assign bus.out_row   = out_q.row;
  assign bus.out_col   = out_q.col;
  assign bus.out_last  = out_q.last;
  assign bus.done      = done_q;

  always_comb begin
    state_d        = state_q;
    a_val_d        = a_val_q;
    a_row_d        = a_row_q;
    a_col_d        = a_col_q;
    a_last_d       = a_last_q;
    ptr_d          = ptr_q;
    end_d          = end_q;
    out_d          = out_q;
    out_valid_d    = out_valid_q;
    done_d         = 1'b0;
    bus.a_ready    = 1'b0;
    bus.ptr_rd_en  = 1'b0;
    bus.ptr_addr   = '0;
    bus.elem_rd_en = 1'b0;
    bus.elem_addr  = '0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so nothing is accepted while reset is held.
        bus.a_ready = rst_n;
        if (bus.a_valid && rst_n) begin
          a_val_d       = bus.a_val;
          a_row_d       = bus.a_row;
          a_col_d       = bus.a_col;
          a_last_d      = bus.a_last;
          bus.ptr_rd_en = 1'b1;
          bus.ptr_addr  = bus.a_col;
          state_d       = S_PTR_LO;
        end
      end
      S_PTR_LO: begin
        ptr_d         = bus.ptr_rdata;
        bus.ptr_rd_en = 1'b1;
        bus.ptr_addr  = a_col_q + IDX_W'(1);
        state_d       = S_PTR_HI;
      end
      S_PTR_HI: begin
        end_d = bus.ptr_rdata;
        if (bus.ptr_rdata <= ptr_q) begin
          // Empty (or malformed) B row: nothing to emit.
          state_d = S_IDLE;
          done_d  = a_last_q;
        end else begin
          bus.elem_rd_en = 1'b1;
          bus.elem_addr  = ptr_q;
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        out_d.val   = prod;
        out_d.row   = a_row_q;
        out_d.col   = bus.elem_col;
        out_d.last  = a_last_q && (ptr_inc == end_q);
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_d.last  = 1'b0;
          if (more) begin
            ptr_d          = ptr_inc;
            bus.elem_rd_en = 1'b1;
            bus.elem_addr  = ptr_inc;
            state_d        = S_LOAD;
          end else begin
            state_d = S_IDLE;
            done_d  = a_last_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_val_q     <= '0;
      a_row_q     <= '0;
      a_col_q     <= '0;
      a_last_q    <= 1'b0;
      ptr_q       <= '0;
      end_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_val_q     <= a_val_d;
      a_row_q     <= a_row_d;
      a_col_q     <= a_col_d;
      a_last_q    <= a_last_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_sp_pp_gen.sv
// tb_sp_pp_gen
//   Bench for sp_pp_gen: behavioural rowptr/B memories with one-cycle read
//   latency, an expected-product queue checked at every output handshake,
//   and a per-cycle trace of the control outputs for timing checks.
module tb_sp_pp_gen;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int PW = 16;

  typedef struct packed {
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [DW-1:0] val;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_pp_gen_if #(.DATA_W(DW), .IDX_W(IW), .PTR_W(PW)) bus ();
  sp_pp_gen #(.DATA_W(DW), .IDX_W(IW), .PTR_W(PW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // CSR store models
  logic [PW-1:0] rowptr [0:63];
  logic [DW-1:0] bval   [0:63];
  logic [IW-1:0] bcol   [0:63];
  always @(posedge clk) begin
    if (bus.ptr_rd_en) bus.ptr_rdata <= rowptr[bus.ptr_addr[5:0]];
    if (bus.elem_rd_en) begin
      bus.elem_val <= bval[bus.elem_addr[5:0]];
      bus.elem_col <= bcol[bus.elem_addr[5:0]];
    end
  end

  // per-cycle trace, sampled on the falling edge
  int   cyc = 0;
  logic tr_ov [0:2047];
  logic tr_dn [0:2047];
  logic tr_pr [0:2047];
  logic tr_er [0:2047];
  logic tr_ar [0:2047];
  logic [IW+IW+DW-1:0] tr_dat [0:2047];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    tr_ov[cyc]  = bus.out_valid;
    tr_dn[cyc]  = bus.done;
    tr_pr[cyc]  = bus.ptr_rd_en;
    tr_er[cyc]  = bus.elem_rd_en;
    tr_ar[cyc]  = bus.a_ready;
    tr_dat[cyc] = {bus.out_row, bus.out_col, bus.out_val};
  end

  // scoreboard
  beat_t exp_q[$];
  beat_t sb_e;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got row=%0d col=%0d val=%h last=%b, required no output",
                 bus.out_row, bus.out_col, bus.out_val, bus.out_last);
      end else begin
        sb_e = exp_q.pop_front();
        if ({bus.out_row, bus.out_col, bus.out_val, bus.out_last} !== sb_e) begin
          bad++;
          $display("FAIL sb_product: got row=%0d col=%0d val=%h last=%b, required row=%0d col=%0d val=%h last=%b",
                   bus.out_row, bus.out_col, bus.out_val, bus.out_last,
                   sb_e.row, sb_e.col, sb_e.val, sb_e.last);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one A nonzero; t0 is the trace index of its handshake cycle.
  task automatic send_a(input logic [IW-1:0] row, input logic [IW-1:0] col,
                        input logic [DW-1:0] val, input logic last, output int t0);
    bit rdy = 0;
    bus.a_row = row; bus.a_col = col; bus.a_val = val; bus.a_last = last;
    bus.a_valid = 1'b1;
    for (int n = 0; n < 50 && !rdy; n++) begin
      @(negedge clk);
      rdy = bus.a_ready;
      t0  = cyc;
      if (!rdy) begin @(posedge clk); #1; end
    end
    total++;
    if (!rdy) begin
      bad++;
      $display("FAIL a_ready_timeout: a_ready=0 after 50 cycles, required 1");
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    bit got = 0;
    for (int n = 0; n < maxc && !got; n++) begin
      @(negedge clk);
      got = bus.done;
      @(posedge clk); #1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_done: done not seen within %0d cycles, required pulse", nm, maxc);
    end
  endtask

  task automatic sb_empty(input string nm);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_sb_left: %0d expected products never emitted, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({bus.a_ready, bus.out_valid, bus.out_last, bus.done, bus.ptr_rd_en, bus.elem_rd_en,
         bus.out_val, bus.out_row, bus.out_col} !== '0) begin
      bad++;
      $display("FAIL reset_vals: rdy=%b ov=%b ol=%b dn=%b prd=%b erd=%b val=%h row=%h col=%h, required all 0",
               bus.a_ready, bus.out_valid, bus.out_last, bus.done, bus.ptr_rd_en,
               bus.elem_rd_en, bus.out_val, bus.out_row, bus.out_col);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t0;
    logic [3:0] got, want;
    exp_q.push_back('{row: 0, col: 5, val: 21, last: 1'b0});
    exp_q.push_back('{row: 0, col: 9, val: 6,  last: 1'b1});
    send_a(0, 2, 3, 1'b1, t0);
    idle(9);
    for (int c = 0; c < 9; c++) begin
      got  = {tr_ov[t0+c], tr_dn[t0+c], tr_pr[t0+c], tr_er[t0+c]};
      want = {(c == 4 || c == 6), (c == 7), (c <= 1), (c == 2 || c == 4)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL basic_trace c=%0d: {ov,done,prd,erd}=%b, required %b", c, got, want);
      end
    end
    sb_empty("basic");
  endtask

  task automatic test_empty_row();
    int t0;
    logic [3:0] got, want;
    rowptr[7] = 10; rowptr[8] = 10;
    send_a(0, 7, 1, 1'b1, t0);
    idle(6);
    for (int c = 0; c < 6; c++) begin
      got  = {tr_ov[t0+c], tr_dn[t0+c], tr_er[t0+c], tr_ar[t0+c]};
      want = {1'b0, (c == 3), 1'b0, (c == 0 || c >= 3)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL empty_trace c=%0d: {ov,done,erd,rdy}=%b, required %b", c, got, want);
      end
    end
    sb_empty("empty");
  endtask

  task automatic test_stall();
    int t0;
    logic [3:0] got, want;
    exp_q.push_back('{row: 0, col: 5, val: 21, last: 1'b0});
    exp_q.push_back('{row: 0, col: 9, val: 6,  last: 1'b1});
    send_a(0, 2, 3, 1'b1, t0);
    bus.out_ready = 1'b0;
    idle(8);
    bus.out_ready = 1'b1;
    idle(6);
    for (int c = 0; c < 13; c++) begin
      got  = {tr_ov[t0+c], tr_dn[t0+c], tr_pr[t0+c], tr_er[t0+c]};
      want = {((c >= 4 && c <= 9) || c == 11), (c == 12), (c <= 1), (c == 2 || c == 9)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stall_trace c=%0d: {ov,done,prd,erd}=%b, required %b", c, got, want);
      end
    end
    for (int c = 4; c <= 9; c++) begin
      total++;
      if (tr_dat[t0+c] !== {16'd0, 16'd5, 32'd21}) begin
        bad++;
        $display("FAIL stall_hold c=%0d: {row,col,val}=%h, required %h", c, tr_dat[t0+c],
                 {16'd0, 16'd5, 32'd21});
      end
    end
    sb_empty("stall");
  endtask

  task automatic test_wrap();
    int t0, t1;
    rowptr[11] = 20; rowptr[12] = 21; bval[20] = 32'h0001_0000; bcol[20] = 1;
    rowptr[13] = 22; rowptr[14] = 23; bval[22] = 32'd2;         bcol[22] = 4;
    exp_q.push_back('{row: 2, col: 1, val: 32'h0000_0000, last: 1'b0});
    exp_q.push_back('{row: 3, col: 4, val: 32'hFFFF_FFFE, last: 1'b1});
    send_a(2, 11, 32'h0001_0000, 1'b0, t0);
    send_a(3, 13, 32'hFFFF_FFFF, 1'b1, t1);
    wait_done(30, "wrap");
    idle(2);
    sb_empty("wrap");
  endtask

  task automatic test_reset_mid();
    int t0;
    bus.out_ready = 1'b0;
    send_a(0, 2, 3, 1'b1, t0);
    idle(3);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: out_valid=%b, required 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.a_ready, bus.done, bus.out_val} !== '0) begin
      bad++;
      $display("FAIL rstmid_async: {ov,rdy,done}=%b val=%h, required 0",
               {bus.out_valid, bus.a_ready, bus.done}, bus.out_val);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.a_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_release: {rdy,ov}=%b, required 10", {bus.a_ready, bus.out_valid});
    end
    bus.out_ready = 1'b1;
    exp_q.push_back('{row: 0, col: 5, val: 21, last: 1'b0});
    exp_q.push_back('{row: 0, col: 9, val: 6,  last: 1'b1});
    send_a(0, 2, 3, 1'b1, t0);
    wait_done(20, "rstmid");
    idle(2);
    sb_empty("rstmid");
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    rowptr[1] = 3; bval[3] = 4; bcol[3] = 3;
    exp_q.push_back('{row: 0, col: 3, val: 8,  last: 1'b0});
    exp_q.push_back('{row: 1, col: 3, val: 20, last: 1'b1});
    send_a(0, 1, 2, 1'b0, t0);
    send_a(1, 1, 5, 1'b1, t1);
    wait_done(20, "b2b");
    idle(2);
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (tr_ar[t0+c] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_busy c=%0d: a_ready=%b, required 0", c, tr_ar[t0+c]);
      end
    end
    total++;
    if (t1 - t0 != 5) begin
      bad++;
      $display("FAIL b2b_accept: second A accepted at cycle %0d, required 5", t1 - t0);
    end
    sb_empty("b2b");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin rowptr[i] = '0; bval[i] = '0; bcol[i] = '0; end
    rowptr[2] = 4; rowptr[3] = 6;
    bval[4] = 7; bcol[4] = 5;
    bval[5] = 2; bcol[5] = 9;
    bus.a_valid = 1'b0; bus.a_val = '0; bus.a_row = '0; bus.a_col = '0; bus.a_last = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_empty_row();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sp_pp_gen.md
# sp_pp_gen

Partial-product generator for the row-wise (Gustavson) SpGEMM datapath. It consumes a stream of A nonzeros (row i, col k, value a) and fetches row k of B from a CSR store through synchronous-read memory ports. It emits one product (i, j, a·b) per B nonzero on a valid/ready stream. Its output feeds the merge/accumulate PE's `in_*` stream directly.

## Interface
Parameters:
- DATA_W, 32, width of A/B/product values
- IDX_W, 16, width of row/column indices
- PTR_W, 16, width of CSR row-pointer and element addresses

Ports:
- Clocking and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- a_valid  in  1  A nonzero valid
- a_ready  out  1  A nonzero accepted when a_valid&&a_ready
- a_val  in  DATA_W  A value
- a_row  in  IDX_W  A row i
- a_col  in  IDX_W  A column k (= B row index)
- a_last  in  1  final A nonzero of the matrix
- ptr_rd_en  out  1  row-pointer read strobe
- ptr_addr  out  IDX_W  row-pointer address
- ptr_rdata  in  PTR_W  rowptr[ptr_addr], valid the cycle after ptr_rd_en
- elem_rd_en  out  1  B element read strobe
- elem_addr  out  PTR_W  B element address
- elem_val  in  DATA_W  B value, valid the cycle after elem_rd_en
- elem_col  in  IDX_W  B column j, valid the cycle after elem_rd_en
- out_valid  out  1  product valid (registered)
- out_ready  in  1  downstream accept
- out_val  out  DATA_W  product a·b
- out_row  out  IDX_W  i
- out_col  out  IDX_W  j
- out_last  out  1  final product of the matrix
- done  out  1  one-cycle pulse, last A nonzero fully processed

## Operation
- Architecture: an FSM with the states S_IDLE, S_PTR_LO, S_PTR_HI, S_LOAD, S_EMIT. It uses registers a_val_q, a_row_q, a_last_q, ptr_q (current element address), and end_q.
- S_IDLE:
  - a_ready=1. It depends on state only, not on a_valid.
  - On handshake: capture the A fields; drive ptr_rd_en=1 and ptr_addr=a_col combinationally; go to S_PTR_LO.
- S_PTR_LO:
  - ptr_q←ptr_rdata (start).
  - Issue a row-pointer read at a_col_q+1.
  - Go to S_PTR_HI.
- S_PTR_HI:
  - end_q←ptr_rdata.
  - If ptr_rdata ≤ ptr_q (empty or malformed row): go to S_IDLE. Pulse done if a_last_q.
  - Otherwise: elem_rd_en=1, elem_addr=ptr_q; go to S_LOAD.
- S_LOAD:
  - Register out_val=(a_val_q·elem_val) mod 2^DATA_W, unsigned, low bits of the full 2·DATA_W product.
  - Register out_col=elem_col, out_row=a_row_q, out_valid←1.
  - out_last←a_last_q && (ptr_q+1==end_q).
  - Go to S_EMIT.
- S_EMIT:
  - out_valid=1 and all out_* fields are held stable.
  - On out_ready: out_valid←0.
    - If ptr_q+1<end_q: ptr_q←ptr_q+1, issue an element read at ptr_q+1, go to S_LOAD.
    - Otherwise: go to S_IDLE; done pulses in the following cycle if a_last_q.
- No read strobe is asserted except as listed above. Both strobes stay 0 while stalled in S_EMIT.
- Column-range checking is not performed here. The downstream PE rejects j≥2048.

## Timing
- Reset values:
  - a_ready=0 while rst_n=0.
  - out_valid, out_last, done, ptr_rd_en, elem_rd_en = 0.
  - out_val, out_row, out_col = 0.
  - State = S_IDLE.
- A handshake at cycle 0:
  - row-pointer reads at cycles 0 and 1;
  - element read at cycle 2;
  - out_valid first high at cycle 4.
- Throughput is 1 product per 2 cycles with out_ready held high.
- Each further A nonzero adds at least 3 cycles of pointer overhead. For an empty B row, a_ready is high again at cycle 3.
- out_valid never drops without a handshake. Stall duration is unbounded.
- done is high one cycle after the final S_EMIT handshake, or one cycle after S_PTR_HI for an empty final row. If the final B row is empty, no out_last is emitted.
- Reset asserted mid-operation: all outputs go to reset values immediately (async) and any in-flight product is discarded. a_ready=1 in the first cycle after rst_n rises.

## Test plan
- A=(i0,k2,3), rowptr[2]=4, rowptr[3]=6, B[4]=(j5,7), B[5]=(j9,2), out_ready=1, a_last=1 -> outputs (0,5,21) at cycle 4 and (0,9,6) at cycle 6. out_last only on the second; done at cycle 7.
- rowptr[k]=rowptr[k+1]=10, a_last=1 -> no out_valid; elem_rd_en never asserted; done and a_ready high at cycle 3.
- Same stimulus as scenario 1 with out_ready=0 for cycles 4–8 -> out_* stable (0,5,21); no reads issued; second product 2 cycles after the accept at cycle 9.
- a_val=0x0001_0000, B value 0x0001_0000 -> out_val=0 (wrap). a_val=0xFFFF_FFFF, B value=2 -> out_val=0xFFFF_FFFE.
- rst_n pulsed low during S_EMIT -> out_valid=0 asynchronously; a_ready=1 on the first clock after release; a new A element is processed normally.
- A stream (0,1,2),(1,1,5) with row 1 of B=(j3,4) -> (0,3,8) then (1,3,20), correctly row-tagged; a_ready low throughout the first element's processing.
